// File: rtl/monpro_modexp.sv
// monpro_modexp: radix-2 bit-serial Montgomery modular exponentiation.
// Define MONPRO_SKIP_LEADING_ZEROS_EN to skip leading zero exponent bits.
module monpro_modexp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startInput,
    input  logic                  getResult,
    input  logic [DATA_WIDTH-1:0] m_input,
    input  logic [DATA_WIDTH-1:0] e_input,
    input  logic [DATA_WIDTH-1:0] n_input,
    output logic [3:0]            state,
    output logic [4:0]            exp_state,
    output logic [DATA_WIDTH-1:0] res_out
);
    localparam int K   = DATA_WIDTH * NUM_WORDS;
    localparam int CW  = $clog2(2 * K) + 1;
    localparam int JW  = $clog2(K);
    localparam int DSH = $clog2(DATA_WIDTH);

    localparam logic [K-1:0] ONE = K'(1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD     = 4'd1,
        PRECOMP  = 4'd2,
        TOMONT_M = 4'd3,
        TOMONT_X = 4'd4,
        SQUARE   = 4'd5,
        MULT     = 4'd6,
        FROMMONT = 4'd7,
        DONE     = 4'd8,
        UNLOAD   = 4'd9
`ifdef MONPRO_SKIP_LEADING_ZEROS_EN
        , SCAN   = 4'd10
`endif
    } state_e;

`ifdef MONPRO_SKIP_LEADING_ZEROS_EN
    localparam state_e FIRST = SCAN;
`else
    localparam state_e FIRST = SQUARE;
`endif

    state_e                state_q;
    logic [4:0]            k_q;
    logic [CW-1:0]         cnt_q;
    logic [JW-1:0]         j_q;
    logic [K-1:0]          n_q;
    logic [K-1:0]          m_q;
    logic [K-1:0]          e_q;
    logic [K-1:0]          r2_q;
    logic [K-1:0]          mbar_q;
    logic [K-1:0]          x_q;
    logic [K+1:0]          s_q;
    logic [DATA_WIDTH-1:0] res_q;

    logic [K-1:0] a_op;
    logic [K-1:0] b_op;
    logic         a_bit;
    logic         mp_last;
    logic [K+1:0] n_ext;
    logic [K+1:0] s_add;
    logic [K+1:0] s_odd;
    logic [K+1:0] s_d;
    logic [K-1:0] mp_res;
    logic [K+1:0] pre_dbl;
    logic [K-1:0] r2_d;
    logic [4:0]   k_d;

    always_comb begin
        a_op = x_q;
        b_op = x_q;
        unique case (state_q)
            TOMONT_M: begin a_op = m_q;    b_op = r2_q; end
            TOMONT_X: begin a_op = ONE;    b_op = r2_q; end
            MULT:     begin a_op = mbar_q; b_op = x_q;  end
            FROMMONT: begin a_op = x_q;    b_op = ONE;  end
            default:  ;
        endcase
    end

    // One Montgomery iteration; S stays below 2N so K+2 bits never overflow
    always_comb begin
        n_ext   = {2'b00, n_q};
        a_bit   = a_op[cnt_q[JW-1:0]];
        mp_last = (cnt_q == CW'(K));
        s_add   = s_q + (a_bit ? {2'b00, b_op} : '0);
        s_odd   = s_add[0] ? s_add + n_ext : s_add;
        s_d     = s_odd >> 1;
        mp_res  = (s_q >= n_ext) ? K'(s_q - n_ext) : s_q[K-1:0];
        pre_dbl = {1'b0, r2_q, 1'b0};
        r2_d    = (pre_dbl >= n_ext) ? K'(pre_dbl - n_ext)
                                     : pre_dbl[K-1:0];
        k_d     = k_q + 5'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            j_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            e_q     <= '0;
            r2_q    <= '0;
            mbar_q  <= '0;
            x_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE, LOAD: begin
                    if (startInput) begin
                        n_q[k_q*DATA_WIDTH +: DATA_WIDTH] <= n_input;
                        m_q[k_q*DATA_WIDTH +: DATA_WIDTH] <= m_input;
                        e_q[k_q*DATA_WIDTH +: DATA_WIDTH] <= e_input;
                        if (k_q == 5'(NUM_WORDS - 1)) begin
                            state_q <= PRECOMP;
                            k_q     <= '0;
                            cnt_q   <= '0;
                            r2_q    <= ONE;
                        end else begin
                            state_q <= LOAD;
                            k_q     <= k_d;
                        end
                    end
                end
                PRECOMP: begin
                    r2_q  <= r2_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(2 * K - 1)) begin
                        state_q <= TOMONT_M;
                        cnt_q   <= '0;
                        s_q     <= '0;
                    end
                end
                TOMONT_M, TOMONT_X, SQUARE, MULT, FROMMONT: begin
                    if (!mp_last) begin
                        s_q   <= s_d;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        s_q   <= '0;
                        cnt_q <= '0;
                        unique case (state_q)
                            TOMONT_M: begin
                                mbar_q  <= mp_res;
                                state_q <= TOMONT_X;
                            end
                            TOMONT_X: begin
                                x_q     <= mp_res;
                                j_q     <= JW'(K - 1);
                                state_q <= FIRST;
                            end
                            SQUARE: begin
                                x_q <= mp_res;
                                if (e_q[j_q]) begin
                                    state_q <= MULT;
                                end else if (j_q == '0) begin
                                    state_q <= FROMMONT;
                                end else begin
                                    j_q <= j_q - 1'b1;
                                end
                            end
                            MULT: begin
                                x_q <= mp_res;
                                if (j_q == '0) begin
                                    state_q <= FROMMONT;
                                end else begin
                                    j_q     <= j_q - 1'b1;
                                    state_q <= SQUARE;
                                end
                            end
                            default: begin
                                x_q     <= mp_res;
                                state_q <= DONE;
                            end
                        endcase
                    end
                end
`ifdef MONPRO_SKIP_LEADING_ZEROS_EN
                SCAN: begin
                    if (e_q[j_q]) begin
                        state_q <= SQUARE;
                    end else if (j_q == '0) begin
                        state_q <= FROMMONT;
                    end else begin
                        j_q <= j_q - 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (getResult) begin
                        res_q   <= x_q[0 +: DATA_WIDTH];
                        k_q     <= '0;
                        state_q <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (k_q == 5'(NUM_WORDS - 1)) begin
                        k_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        k_q   <= k_d;
                        res_q <= x_q[k_d*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign exp_state = (state_q == SQUARE || state_q == MULT)
                     ? 5'(j_q >> DSH) : k_q;
    assign res_out   = res_q;

endmodule

// File: tb/tb_monpro_modexp.sv
// tb_monpro_modexp: vector table, corner sequences and random checks
// of monpro_modexp at 8-bit words, two words per operand.
module tb_monpro_modexp;
    localparam int DW = 8;
    localparam int NW = 2;
    localparam int K  = DW * NW;

    logic          clk = 1'b0;
    logic          reset;
    logic          startInput;
    logic          getResult;
    logic [DW-1:0] m_input;
    logic [DW-1:0] e_input;
    logic [DW-1:0] n_input;
    logic [3:0]    state;
    logic [4:0]    exp_state;
    logic [DW-1:0] res_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    monpro_modexp #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .startInput(startInput),
        .getResult (getResult),
        .m_input   (m_input),
        .e_input   (e_input),
        .n_input   (n_input),
        .state     (state),
        .exp_state (exp_state),
        .res_out   (res_out)
    );

    typedef struct {
        logic [K-1:0] n;
        logic [K-1:0] m;
        logic [K-1:0] e;
        logic [K-1:0] res;
    } vec_t;

    task automatic check(input string name, input longint act,
                         input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic longint ref_modexp(longint n, longint m, longint e);
        longint r = 1 % n;
        longint b = m % n;
        for (int i = 0; i < K; i++) begin
            if (((e >> i) & 1) == 1) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r;
    endfunction

    function automatic int ref_cycles(logic [K-1:0] e);
        return 2 * K + (K + 1) * (K + 3 + $countones(e));
    endfunction

    task automatic load(input logic [K-1:0] n, input logic [K-1:0] m,
                        input logic [K-1:0] e, input int stall_at);
        for (int w = 0; w < NW; w++) begin
            if (w == stall_at) begin
                startInput = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    check($sformatf("stall_state%0d", s), state, 1);
                end
            end
            startInput = 1'b1;
            n_input = n[w*DW +: DW];
            m_input = m[w*DW +: DW];
            e_input = e[w*DW +: DW];
            @(posedge clk); #1;
        end
        startInput = 1'b0;
    endtask

    task automatic run(input string tag, input logic [K-1:0] n,
                       input logic [K-1:0] m, input logic [K-1:0] e,
                       input int stall_at, output logic [K-1:0] res,
                       output int cyc);
        res = '0;
        load(n, m, e, stall_at);
        cyc = 0;
        while (state != 4'd8 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done"}, state, 8);
        getResult = 1'b1;
        @(posedge clk); #1;
        getResult = 1'b0;
        for (int w = 0; w < NW; w++) begin
            check($sformatf("%s_unload_state%0d", tag, w), state, 9);
            check($sformatf("%s_unload_idx%0d", tag, w), exp_state, w);
            res[w*DW +: DW] = res_out;
            @(posedge clk); #1;
        end
        check({tag, "_idle"}, state, 0);
        check({tag, "_hold"}, res_out, res[(NW-1)*DW +: DW]);
    endtask

    task automatic check_cycles(input string tag, input int cyc,
                                input logic [K-1:0] e);
`ifdef MONPRO_SKIP_LEADING_ZEROS_EN
        check({tag, "_fewer_cycles"}, cyc < ref_cycles(e), 1);
`else
        check({tag, "_cycles"}, cyc, ref_cycles(e));
`endif
    endtask

    initial begin
        vec_t         tbl[5];
        logic [K-1:0] res;
        int           cyc;
        logic [K-1:0] n;
        logic [K-1:0] m;
        logic [K-1:0] e;
        int           waited;

        tbl[0] = '{16'h0021, 16'h0005, 16'h0003, 16'h001A};
        tbl[1] = '{16'h0CA1, 16'h0041, 16'h0011, 16'h0AE6};
        tbl[2] = '{16'h0021, 16'h0007, 16'h0000, 16'h0001};
        tbl[3] = '{16'h0021, 16'h0000, 16'h0005, 16'h0000};
        tbl[4] = '{16'h0021, 16'h0007, 16'h0001, 16'h0007};

        reset      = 1'b0;
        startInput = 1'b0;
        getResult  = 1'b0;
        m_input    = '0;
        e_input    = '0;
        n_input    = '0;
        #1;
        check("rst_state", state, 0);
        check("rst_exp_state", exp_state, 0);
        check("rst_res_out", res_out, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // getResult and startInput outside their states do nothing
        getResult = 1'b1;
        @(posedge clk); #1;
        getResult = 1'b0;
        check("ignore_getresult", state, 0);

        for (int i = 0; i < 5; i++) begin
            run($sformatf("vec%0d", i), tbl[i].n, tbl[i].m, tbl[i].e,
                -1, res, cyc);
            check($sformatf("vec%0d_res", i), res, tbl[i].res);
            check_cycles($sformatf("vec%0d", i), cyc, tbl[i].e);
        end

        run("stall", 16'h0CA1, 16'h0041, 16'h0011, 1, res, cyc);
        check("stall_w0", res[7:0], 8'hE6);
        check("stall_w1", res[15:8], 8'h0A);

        load(16'h0CA1, 16'h0041, 16'h0011, -1);
        waited = 0;
        while (state != 4'd5 && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_square", state, 5);
        startInput = 1'b1;
        @(posedge clk); #1;
        startInput = 1'b0;
        check("ignore_start", state, 5);
        #2 reset = 1'b0;
        #1;
        check("abort_state", state, 0);
        check("abort_exp_state", exp_state, 0);
        check("abort_res_out", res_out, 0);
        @(posedge clk); #2 reset = 1'b1;
        run("fresh", 16'h0CA1, 16'h0041, 16'h0011, -1, res, cyc);
        check("fresh_res", res, 16'h0AE6);

        for (int i = 0; i < 6; i++) begin
            n = K'(($urandom_range(1, 32767) << 1) | 1);
            m = K'($urandom_range(0, int'(n) - 1));
            e = K'($urandom_range(0, 65535));
            run($sformatf("rnd%0d", i), n, m, e, -1, res, cyc);
            check($sformatf("rnd%0d_res", i), res, ref_modexp(n, m, e));
            check_cycles($sformatf("rnd%0d", i), cyc, e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
